// File: rtl/regfile_writeback_arb_if.sv
// regfile_writeback_arb_if: result, scoreboard and regfile-write signals of the writeback arbiter.
// Bypass read signals exist only when WB_BYPASS_EN is defined.
interface regfile_writeback_arb_if;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [31:0] busy_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`ifdef WB_BYPASS_EN
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] rf_readA, rf_readB;
  logic [31:0] fwd_readA, fwd_readB;
`endif
  modport slave (
    input  alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, md_issue, md_issue_reg,
`ifdef WB_BYPASS_EN
    input  ctrl_readRegA, ctrl_readRegB, rf_readA, rf_readB,
    output fwd_readA, fwd_readB,
`endif
    output md_ready, busy_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
  modport master (
    output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data, md_issue, md_issue_reg,
`ifdef WB_BYPASS_EN
    output ctrl_readRegA, ctrl_readRegB, rf_readA, rf_readB,
    input  fwd_readA, fwd_readB,
`endif
    input  md_ready, busy_mask, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/regfile_writeback_arb.sv
// regfile_writeback_arb: merges ALU and buffered mult/div results onto the regfile write port.
// Optional write-to-read bypass enabled by defining WB_BYPASS_EN.
module regfile_writeback_arb #(
  parameter int MD_DEPTH = 4,
  parameter int MD_AW    = 2
) (
  input logic clock,
  input logic ctrl_reset_n,
  regfile_writeback_arb_if.slave wb
);
  logic [4:0]    reg_mem [MD_DEPTH];
  logic [31:0]   dat_mem [MD_DEPTH];
  logic [MD_AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [MD_AW:0]   cnt_q, cnt_d;
  logic [31:0]   busy_q, busy_d, set_m, clr_m;
  logic          we_q, we_d;
  logic [4:0]    wreg_q, wreg_d, win_reg;
  logic [31:0]   wdata_q, wdata_d, win_data;
  logic          full, empty, push, pop, win;
  always_comb begin
    full     = cnt_q == (MD_AW+1)'(MD_DEPTH);
    empty    = cnt_q == '0;
    push     = wb.md_valid && !full;
    pop      = !wb.alu_valid && !empty;
    win      = wb.alu_valid || !empty;
    win_reg  = wb.alu_valid ? wb.alu_reg : reg_mem[rd_q];
    win_data = wb.alu_valid ? wb.alu_data : dat_mem[rd_q];
    // reg 0 winners are consumed but never written; address/data then hold
    we_d     = win && win_reg != 5'd0;
    wreg_d   = we_d ? win_reg : wreg_q;
    wdata_d  = we_d ? win_data : wdata_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    cnt_d    = cnt_q + (MD_AW+1)'(push) - (MD_AW+1)'(pop);
    clr_m    = pop ? 32'(1) << reg_mem[rd_q] : 32'd0;
    set_m    = (wb.md_issue && wb.md_issue_reg != 5'd0) ? 32'(1) << wb.md_issue_reg : 32'd0;
    busy_d   = (busy_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      reg_mem[wr_q] <= wb.md_reg;
      dat_mem[wr_q] <= wb.md_data;
    end
  end
  assign wb.md_ready         = !full;
  assign wb.busy_mask        = busy_q;
  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = wreg_q;
  assign wb.data_writeReg    = wdata_q;
`ifdef WB_BYPASS_EN
  assign wb.fwd_readA = (we_q && wreg_q == wb.ctrl_readRegA && wb.ctrl_readRegA != 5'd0) ? wdata_q : wb.rf_readA;
  assign wb.fwd_readB = (we_q && wreg_q == wb.ctrl_readRegB && wb.ctrl_readRegB != 5'd0) ? wdata_q : wb.rf_readB;
`endif
endmodule
